// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states, stream framing and checksum width.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

  // A LEN byte of zero encodes a full 256-byte image.
  localparam int unsigned LEN_ZERO_MEANS_MAX = 256;
  localparam int unsigned CHK_W              = 8;

endpackage

// File: rtl/prog_loader_wr_port.sv
// Registered memory write port; holds strobe/address/data for one cycle after a request.
module prog_loader_wr_port #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              mem_wren_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o
);

  logic              mem_wren_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_wren_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      mem_wren_q <= wr_en_i;
      if (wr_en_i) begin
        mem_addr_q <= wr_addr_i;
        mem_data_q <= wr_data_i;
      end
    end
  end

  assign mem_wren_o = mem_wren_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;

endmodule

// File: rtl/prog_loader.sv
// Loads a LEN/DATA/CHK framed byte stream into instruction memory and keeps the CPU
// held in reset until the image checksum verifies.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DATA_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              run,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   loaded_count
);

  state_e            state_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic              error_q;
  logic [ADDR_W:0]   loaded_count_q;
  logic [DATA_W:0]   remaining_q;
  logic [CHK_W-1:0]  sum_q;

  logic              accept;
  logic [CHK_W-1:0]  sum_d;
  logic [DATA_W:0]   frame_len_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;

  assign in_ready    = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);
  assign accept      = in_valid && in_ready;
  assign sum_d       = sum_q + CHK_W'(in_data);
  assign frame_len_d = (in_data == '0) ? (DATA_W+1)'(LEN_ZERO_MEANS_MAX) : {1'b0, in_data};
  assign wr_en_d     = accept && (state_q == ST_DATA);
  assign wr_addr_d   = BASE_ADDR + loaded_count_q[ADDR_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cpu_hold_q     <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      loaded_count_q <= '0;
      remaining_q    <= '0;
      sum_q          <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          // start takes priority; run only leaves IDLE
          if (start) begin
            state_q        <= ST_LEN;
            cpu_hold_q     <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            loaded_count_q <= '0;
            sum_q          <= '0;
          end else if (run && state_q == ST_IDLE) begin
            state_q    <= ST_DONE;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        ST_LEN: begin
          if (accept) begin
            remaining_q <= frame_len_d;
            state_q     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            sum_q          <= sum_d;
            loaded_count_q <= loaded_count_q + (ADDR_W+1)'(1);
            remaining_q    <= remaining_q - (DATA_W+1)'(1);
            if (remaining_q == (DATA_W+1)'(1)) state_q <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (accept) begin
            if (sum_d == '0) begin
              state_q    <= ST_DONE;
              cpu_hold_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q <= ST_ERR;
              error_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  prog_loader_wr_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_port (
    .clock      (clock),
    .reset      (reset),
    .wr_en_i    (wr_en_d),
    .wr_addr_i  (wr_addr_d),
    .wr_data_i  (in_data),
    .mem_wren_o (mem_wren),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_data)
  );

  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign loaded_count = loaded_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (BASE_ADDR 00 and F0) share the stimulus.
module tb_prog_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       run = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;

  logic       rdy0, wren0, hold0, done0, err0;
  logic [7:0] addr0, data0;
  logic [8:0] cnt0;
  logic       rdy1, wren1, hold1, done1, err1;
  logic [7:0] addr1, data1;
  logic [8:0] cnt1;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  prog_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'h00)) dut0 (
    .clock(clock), .reset(reset), .start(start), .run(run),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .mem_wren(wren0), .mem_addr(addr0), .mem_data(data0),
    .cpu_hold(hold0), .done(done0), .error(err0), .loaded_count(cnt0)
  );

  prog_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'hF0)) dut1 (
    .clock(clock), .reset(reset), .start(start), .run(run),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .mem_wren(wren1), .mem_addr(addr1), .mem_data(data1),
    .cpu_hold(hold1), .done(done1), .error(err1), .loaded_count(cnt1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; run = 1'b0; in_valid = 1'b0; in_data = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (hold0 !== 1'b1) $display("FAIL rst_hold got %b want 1", hold0); else pass_cnt++;
    total_cnt++; if (wren0 !== 1'b0) $display("FAIL rst_wren got %b want 0", wren0); else pass_cnt++;
    total_cnt++; if ({addr0, data0} !== 16'h0000) $display("FAIL rst_addr_data got %h want 0000", {addr0, data0}); else pass_cnt++;
    total_cnt++; if ({done0, err0, rdy0} !== 3'b000) $display("FAIL rst_flags got %b want 000", {done0, err0, rdy0}); else pass_cnt++;
    total_cnt++; if (cnt0 !== 9'd0) $display("FAIL rst_count got %0d want 0", cnt0); else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    pulse_start();
    total_cnt++; if (rdy0 !== 1'b1) $display("FAIL basic_ready_len got %b want 1", rdy0); else pass_cnt++;
    send_byte(8'h03);
    total_cnt++; if (wren0 !== 1'b0) $display("FAIL basic_len_nowrite got %b want 0", wren0); else pass_cnt++;
    send_byte(8'h11);
    total_cnt++; if ({wren0, addr0, data0} !== {1'b1, 8'h00, 8'h11}) $display("FAIL basic_wr0 got %h want 10011", {wren0, addr0, data0}); else pass_cnt++;
    send_byte(8'h22);
    total_cnt++; if ({wren0, addr0, data0} !== {1'b1, 8'h01, 8'h22}) $display("FAIL basic_wr1 got %h want 10122", {wren0, addr0, data0}); else pass_cnt++;
    send_byte(8'h33);
    total_cnt++; if ({wren0, addr0, data0} !== {1'b1, 8'h02, 8'h33}) $display("FAIL basic_wr2 got %h want 10233", {wren0, addr0, data0}); else pass_cnt++;
    total_cnt++; if (cnt0 !== 9'd3) $display("FAIL basic_count got %0d want 3", cnt0); else pass_cnt++;
    total_cnt++; if (hold0 !== 1'b1) $display("FAIL basic_hold_loading got %b want 1", hold0); else pass_cnt++;
    send_byte(8'h9A);
    total_cnt++; if (wren0 !== 1'b0) $display("FAIL basic_chk_nowrite got %b want 0", wren0); else pass_cnt++;
    total_cnt++; if ({hold0, done0, err0, rdy0} !== 4'b0100) $display("FAIL basic_done got %b want 0100", {hold0, done0, err0, rdy0}); else pass_cnt++;
  endtask

  task automatic test_bad_chk();
    pulse_start();
    total_cnt++; if ({hold0, done0, rdy0} !== 3'b101) $display("FAIL bad_restart got %b want 101", {hold0, done0, rdy0}); else pass_cnt++;
    total_cnt++; if (cnt0 !== 9'd0) $display("FAIL bad_count_clr got %0d want 0", cnt0); else pass_cnt++;
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h9B);
    total_cnt++; if ({hold0, done0, err0, rdy0} !== 4'b1010) $display("FAIL bad_err got %b want 1010", {hold0, done0, err0, rdy0}); else pass_cnt++;
    run = 1'b1; tick(); run = 1'b0;
    total_cnt++; if ({hold0, done0, err0} !== 3'b101) $display("FAIL bad_run_ignored got %b want 101", {hold0, done0, err0}); else pass_cnt++;
    pulse_start();
    total_cnt++; if ({err0, rdy0, hold0} !== 3'b011) $display("FAIL bad_restart_clr got %b want 011", {err0, rdy0, hold0}); else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    pulse_start();
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
      total_cnt++;
      if ({wren1, addr1, data1} !== {1'b1, 8'(8'hF0 + i), 8'(i)})
        $display("FAIL wrap_wr%0d got %h want %h", i, {wren1, addr1, data1}, {1'b1, 8'(8'hF0 + i), 8'(i)});
      else pass_cnt++;
    end
    total_cnt++; if ({addr1, data1} !== 16'hEFFF) $display("FAIL wrap_last got %h want EFFF", {addr1, data1}); else pass_cnt++;
    total_cnt++; if ({addr0, data0} !== 16'hFFFF) $display("FAIL wrap_last_base0 got %h want FFFF", {addr0, data0}); else pass_cnt++;
    total_cnt++; if (cnt1 !== 9'd256) $display("FAIL wrap_count got %0d want 256", cnt1); else pass_cnt++;
    total_cnt++; if ({rdy1, done1} !== 2'b10) $display("FAIL wrap_in_chk got %b want 10", {rdy1, done1}); else pass_cnt++;
    send_byte(8'h80);
    total_cnt++; if ({hold1, done1, err1} !== 3'b010) $display("FAIL wrap_done got %b want 010", {hold1, done1, err1}); else pass_cnt++;
  endtask

  task automatic test_gaps();
    do_reset();
    pulse_start();
    send_byte(8'h04);
    for (int j = 0; j < 8; j++) begin
      in_valid = (j % 2 == 0);
      in_data  = 8'(j / 2 + 1);
      start    = (j == 1 || j == 4);
      run      = (j == 3 || j == 6);
      tick();
      total_cnt++;
      if (wren0 !== in_valid) $display("FAIL gap_wren%0d got %b want %b", j, wren0, in_valid); else pass_cnt++;
      if (in_valid) begin
        total_cnt++;
        if ({addr0, data0} !== {8'(j / 2), 8'(j / 2 + 1)})
          $display("FAIL gap_wr%0d got %h want %h", j, {addr0, data0}, {8'(j / 2), 8'(j / 2 + 1)});
        else pass_cnt++;
      end
      total_cnt++; if ({rdy0, hold0, done0} !== 3'b110) $display("FAIL gap_state%0d got %b want 110", j, {rdy0, hold0, done0}); else pass_cnt++;
    end
    in_valid = 1'b0; start = 1'b0; run = 1'b0;
    total_cnt++; if (cnt0 !== 9'd4) $display("FAIL gap_count got %0d want 4", cnt0); else pass_cnt++;
    send_byte(8'hF6);
    total_cnt++; if ({hold0, done0, err0} !== 3'b010) $display("FAIL gap_done got %b want 010", {hold0, done0, err0}); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_start();
    send_byte(8'h05); send_byte(8'hA1); send_byte(8'hA2);
    total_cnt++; if (cnt0 !== 9'd2) $display("FAIL mid_count_pre got %0d want 2", cnt0); else pass_cnt++;
    in_valid = 1'b1; in_data = 8'hA3;
    #2 reset = 1'b1;
    #1;
    total_cnt++; if ({wren0, hold0, done0, err0, rdy0} !== 5'b01000) $display("FAIL mid_async got %b want 01000", {wren0, hold0, done0, err0, rdy0}); else pass_cnt++;
    total_cnt++; if ({addr0, data0, cnt0} !== 25'd0) $display("FAIL mid_regs got %h want 0", {addr0, data0, cnt0}); else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
    total_cnt++; if ({wren0, rdy0, hold0} !== 3'b001) $display("FAIL mid_idle got %b want 001", {wren0, rdy0, hold0}); else pass_cnt++;
    in_valid = 1'b0;
  endtask

  task automatic test_run();
    do_reset();
    run = 1'b1; tick(); run = 1'b0;
    total_cnt++; if ({hold0, done0, wren0, rdy0} !== 4'b0100) $display("FAIL run_done got %b want 0100", {hold0, done0, wren0, rdy0}); else pass_cnt++;
    pulse_start();
    total_cnt++; if ({hold0, done0, rdy0} !== 3'b101) $display("FAIL run_restart got %b want 101", {hold0, done0, rdy0}); else pass_cnt++;
    do_reset();
    start = 1'b1; run = 1'b1; tick(); start = 1'b0; run = 1'b0;
    total_cnt++; if ({rdy0, done0, hold0} !== 3'b101) $display("FAIL run_start_wins got %b want 101", {rdy0, done0, hold0}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_chk();
    test_wrap();
    test_gaps();
    test_reset_mid();
    test_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
